ctrl_fsm: RTL
=============

Name: ctrl_fsm

Overview:
Multi-cycle fetch/decode/execute/writeback controller for the 8-bit mini processor. It is the producer side of the ALU interface. It fetches 16-bit instructions over a req/ack port, holds the 4x8 register file, drives ALU op/a/b, and consumes ALU y/zero for writeback and the JNZ branch decision.

Parameters:
- PC_W, 8, program counter / instruction address width.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  PC_W  fetch address (= pc).
- imem_ack  in  1  instruction valid this cycle; ignored when imem_req=0.
- imem_rdata  in  16  instruction word, sampled when imem_req and imem_ack are both high.
- alu_op  out  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 JNZ-test.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_y  in  8  ALU result (combinational from op/a/b).
- alu_zero  in  1  ALU zero flag.
- halted  out  1  high once HALT has executed.
- dbg_sel  in  2  register select for the debug read.
- dbg_data  out  8  combinational read of reg[dbg_sel].

Behaviour:
- Instruction format: [15:13] opcode, [12:11] rd, [10:9] rs, [8:7] rt, [6:0] unused. For JNZ/LI, [7:0] is imm8 and overlaps rt.
- Opcodes:
  - 000 ADD, 001 SUB, 010 AND, 011 OR: rd <= rs op rt.
  - 100 JNZ: if reg[rs]!=0 then pc <= imm8.
  - 101 LI: rd <= imm8.
  - 110 NOP.
  - 111 HALT.
- Reset (async): state=FETCH, pc=RESET_PC, IR=0, all regs=0, imem_req=0, halted=0, alu_op=000, alu_a=0, alu_b=0. imem_req first rises in the cycle after reset deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On ack, IR<=imem_rdata and go to DECODE. With no ack, stay and hold req and addr stable.
  - DECODE (1 cycle): latch opA=reg[rs] and opB=reg[rt]. NOP → WB. HALT → HALT. LI → WB. Everything else → EXEC.
  - EXEC (1 cycle): drive alu_op/alu_a/alu_b from registered values and capture res<=alu_y and zf<=alu_zero.
    - For JNZ: alu_op=100, alu_a=opA, alu_b=0.
    - alu_op/a/b are registered outputs, stable for the whole EXEC cycle.
  - WB (1 cycle):
    - ALU ops: reg[rd]<=res.
    - LI: reg[rd]<=imm8.
    - JNZ: pc<=imm8 if zf==0, else pc+1.
    - All others: pc<=pc+1.
    - Then → FETCH.
  - HALT: halted=1, imem_req=0. Terminal until rst.
- Outside EXEC, alu_op/a/b hold their last values; the ALU result is not used.
- Latency: ALU op and JNZ take 4 cycles when ack arrives in the first FETCH cycle. LI and NOP take 3.
- Arithmetic is 8-bit modulo. SUB underflow wraps (0-1=8'hFF). The pc increment wraps 8'hFF→8'h00.
- All four regs are writable; there is no hardwired zero register.
- Writing rd in WB is visible at the next DECODE, so back-to-back dependencies need no hazard logic.
- imem_ack while imem_req=0 (DECODE/EXEC/WB/HALT) is ignored; IR is unchanged.
- Reset mid-fetch drops imem_req combinationally with rst. A pending ack is discarded.
- JNZ with imm8==pc is a legal self-loop.

Optional Feature:
- CTRL_PERF_CNT_EN.
- Defined: adds output port instret[15:0], reset to 0, incremented in every WB cycle, wrapping 16'hFFFF→0. It does not count HALT and does not count stall cycles.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared header ctrl_defs.vh holds:
  - opcode localparams OP_ADD..OP_HALT;
  - ALU op encodings ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_JNZ=3'b100;
  - FSM state encodings S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT;
  - instruction field bit positions.
- One sub-module, regfile4x8: two combinational read ports plus one debug read port, one synchronous write port, async active-high reset to 0.

Test Plan:
1. Reset, then program LI r0,5; LI r1,3; ADD r2,r0,r1; HALT, with ack on the first FETCH cycle → dbg r2=8'h08, halted=1, imem_req=0 after HALT, LI takes 3 cycles, ADD takes 4 cycles.
2. LI r0,0; LI r1,1; SUB r2,r0,r1 → r2=8'hFF. In EXEC, alu_op=001, alu_a=0, alu_b=1.
3. Loop: LI r0,3; LI r1,1; at addr 2 SUB r0,r0,r1; at addr 3 JNZ r0,2; at addr 4 HALT → SUB executes 3 times, JNZ taken twice (pc→2) and falls through once (pc→4), final r0=0.
4. Memory ack delayed 5 cycles on every fetch → imem_req and imem_addr stable throughout the wait. Spurious acks injected during DECODE/EXEC do not change IR or results.
5. Assert rst mid-FETCH with imem_req=1 → imem_req=0, pc=RESET_PC and regs=0 immediately, without waiting for a clock edge. Execution restarts at addr 0.
6. With CTRL_PERF_CNT_EN defined, run scenario 1 → instret=3 at halt. Without the macro, the same program produces the same register results.

Source files
------------

// File: rtl/ctrl_fsm_pkg.sv
// Shared definitions for the mini-processor controller: opcodes, ALU encodings,
// FSM states and the instruction word layout.
package ctrl_fsm_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned INSTR_W  = 16;
  localparam int unsigned RA_W     = 2;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned IMM_HI   = 7;
  localparam int unsigned IMM_LO   = 0;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR   = 3'b011;
  localparam logic [OPC_W-1:0] OP_JNZ  = 3'b100;
  localparam logic [OPC_W-1:0] OP_LI   = 3'b101;
  localparam logic [OPC_W-1:0] OP_NOP  = 3'b110;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_JNZ = 3'b100;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // [15:13] opcode, [12:11] rd, [10:9] rs, [8:7] rt, [6:0] spare
  typedef struct packed {
    logic [OPC_W-1:0] opc;
    logic [RA_W-1:0]  rd;
    logic [RA_W-1:0]  rs;
    logic [RA_W-1:0]  rt;
    logic [6:0]       spare;
  } instr_t;

  // imm8 overlaps the low bit of rt and the spare field
  function automatic logic [DATA_W-1:0] imm8(input instr_t i);
    logic [INSTR_W-1:0] w;
    w = i;
    return w[IMM_HI:IMM_LO];
  endfunction

  // ADD/SUB/AND/OR share their opcode with the ALU encoding
  function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
    return (opc[2] == 1'b0);
  endfunction

endpackage

// File: rtl/ctrl_fsm_regfile.sv
// 4x8 register file: two combinational read ports, one debug read port,
// one synchronous write port, async active-high reset to zero.
module ctrl_fsm_regfile
  import ctrl_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [RA_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic [RA_W-1:0]   dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_sel];

endmodule

// File: rtl/ctrl_fsm.sv
// Fetch/decode/execute/writeback controller for the 8-bit mini processor.
// Optional macro CTRL_PERF_CNT_EN adds the instret retired-instruction counter.
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
)
(
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_y,
  input  logic                alu_zero,
  output logic                halted,
  input  logic [RA_W-1:0]     dbg_sel,
  output logic [DATA_W-1:0]   dbg_data
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [15:0]         instret
`endif
);

  state_t            state, state_nx;
  instr_t            ir;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] res;
  logic              zf;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic              wr_en_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              fire_c;

  assign fire_c    = imem_req & imem_ack;
  assign imem_addr = pc;

  ctrl_fsm_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (ir.rs),
    .rd_data_a (rs_data),
    .rd_addr_b (ir.rt),
    .rd_data_b (rt_data),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .wr_en     (wr_en_c),
    .wr_addr   (ir.rd),
    .wr_data   (wr_data_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and register-file write control
  always_comb begin
    state_nx  = state;
    wr_en_c   = 1'b0;
    wr_data_c = res;
    unique case (state)
      S_FETCH: begin
        if (fire_c) state_nx = S_DECODE;
      end
      S_DECODE: begin
        unique case (ir.opc)
          OP_NOP, OP_LI: state_nx = S_WB;
          OP_HALT:       state_nx = S_HALT;
          default:       state_nx = S_EXEC;
        endcase
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        state_nx = S_FETCH;
        if (is_alu_op(ir.opc)) begin
          wr_en_c = 1'b1;
        end else if (ir.opc == OP_LI) begin
          wr_en_c   = 1'b1;
          wr_data_c = imm8(ir);
        end
      end
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // Request is high in every FETCH cycle except the first one after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req <= 1'b0;
      halted   <= 1'b0;
    end else begin
      imem_req <= (state_nx == S_FETCH);
      halted   <= (state_nx == S_HALT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      pc     <= RESET_PC;
      res    <= '0;
      zf     <= 1'b0;
      alu_op <= ALU_ADD;
      alu_a  <= '0;
      alu_b  <= '0;
    end else begin
      if (state == S_FETCH && fire_c) begin
        ir <= instr_t'(imem_rdata);
      end
      // Operands are latched on the way into EXEC so they are stable all cycle
      if (state == S_DECODE && state_nx == S_EXEC) begin
        alu_a <= rs_data;
        if (ir.opc == OP_JNZ) begin
          alu_op <= ALU_JNZ;
          alu_b  <= '0;
        end else begin
          alu_op <= ALU_OP_W'(ir.opc);
          alu_b  <= rt_data;
        end
      end
      if (state == S_EXEC) begin
        res <= alu_y;
        zf  <= alu_zero;
      end
      if (state == S_WB) begin
        if (ir.opc == OP_JNZ && !zf) begin
          pc <= PC_W'(imm8(ir));
        end else begin
          pc <= pc + PC_W'(1);
        end
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (state == S_WB) begin
      instret <= instret + 16'd1;
    end
  end
`endif

endmodule
